// File: rtl/controller_pio_in.sv
// controller_pio_in -- Avalon-MM input-port peripheral.
//
// Samples an asynchronous WIDTH-bit input bus through a two-flop
// synchronizer, optionally debounces each bit, captures enabled rising and
// falling edges into a write-1-to-clear register and raises a level irq for
// captured edges that are unmasked.
//
// Optional feature: define CONTROLLER_PIO_IN_DEBOUNCE_EN to add a per-bit
// debounce filter (DEBOUNCE_CYCLES stable cycles before the filtered value
// follows the pin). Without it the filter is a plain register stage.
//
// Register map (word address):
//   0 DATA (RO)  1 RISE_EN  2 IRQ_MASK  3 EDGE_CAP (W1C)  4 FALL_EN  5-7 zero
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   address      register word address
//   chipselect   slave select; write strobe = chipselect & ~write_n
//   write_n      active-low write strobe
//   writedata    write data, bits [WIDTH-1:0] used
//   in_port      asynchronous external inputs
//   readdata     registered read data (latency 1), upper bits zero
//   irq          level interrupt, |(EDGE_CAP & IRQ_MASK)
module controller_pio_in #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1_q, s2_q, filt_q, prev_q;
    logic [WIDTH-1:0] filt_d, prev_d;
    logic [WIDTH-1:0] rise_en_q, fall_en_q, irq_mask_q, edge_cap_q;
    logic [WIDTH-1:0] rise_en_d, fall_en_d, irq_mask_d, edge_cap_d;
    logic [1:0]       arm_q, arm_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr;
    logic             armed;
    logic [WIDTH-1:0] rise, fall, clr;

    logic unused_wdata;
    assign unused_wdata = ^writedata;

`ifdef CONTROLLER_PIO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
`endif

    // Arming: the counter saturates at 3. Until then the filter and the
    // previous-value stage are both loaded straight from the synchronizer,
    // so the pin state present at reset release never looks like an edge.
    assign armed = (arm_q == 2'd3);

    always_comb begin
        wr    = chipselect & ~write_n;
        arm_d = armed ? arm_q : arm_q + 2'd1;

`ifdef CONTROLLER_PIO_IN_DEBOUNCE_EN
        filt_d = filt_q;
        cnt_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!armed) begin
                filt_d[i] = s2_q[i];
            end else if (s2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
`else
        filt_d = s2_q;
`endif
        prev_d = armed ? filt_q : s2_q;

        rise = armed ? (filt_q & ~prev_q & rise_en_q) : '0;
        fall = armed ? (~filt_q & prev_q & fall_en_q) : '0;
        clr  = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
        // A new edge on the same edge as its W1C keeps the bit set.
        edge_cap_d = rise | fall | (edge_cap_q & ~clr);

        rise_en_d  = (wr && address == 3'd1) ? writedata[WIDTH-1:0] : rise_en_q;
        irq_mask_d = (wr && address == 3'd2) ? writedata[WIDTH-1:0] : irq_mask_q;
        fall_en_d  = (wr && address == 3'd4) ? writedata[WIDTH-1:0] : fall_en_q;

        readdata_d = '0;
        case (address)
            3'd0:    readdata_d[WIDTH-1:0] = filt_q;
            3'd1:    readdata_d[WIDTH-1:0] = rise_en_q;
            3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            3'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
            3'd4:    readdata_d[WIDTH-1:0] = fall_en_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            arm_q      <= '0;
            readdata_q <= '0;
`ifdef CONTROLLER_PIO_IN_DEBOUNCE_EN
            cnt_q      <= '0;
`endif
        end else begin
            s1_q       <= in_port;
            s2_q       <= s1_q;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            arm_q      <= arm_d;
            readdata_q <= readdata_d;
`ifdef CONTROLLER_PIO_IN_DEBOUNCE_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_controller_pio_in.sv
// Self-checking bench for controller_pio_in: directed scenarios plus random
// pin/bus traffic, every cycle compared against a transaction-level model.
module tb_controller_pio_in;
    localparam int W  = 10;
    localparam int DC = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    controller_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: pin samples kept in a history queue (newest first);
    // the filter sees the sample taken two edges earlier.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_filt, m_prev, m_cap, m_re, m_fe, m_mask;
    logic [31:0]  m_rd;
    int           m_edges;
    int           m_run[W];  // consecutive armed edges the pin disagreed with filt

    task automatic tick();
        logic [W-1:0] s2, nf, np, newcap, clr;
        logic [31:0]  rd;
        bit           wr, armed;
        if (reset) begin
            hist.delete();
            m_filt = '0; m_prev = '0; m_cap = '0; m_re = '0; m_fe = '0; m_mask = '0;
            m_rd = '0; m_edges = 0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            s2    = (hist.size() >= 2) ? hist[1] : '0;
            armed = (m_edges >= 3);
            wr    = chipselect && !write_n;
            rd    = '0;
            case (address)
                3'd0: rd[W-1:0] = m_filt;
                3'd1: rd[W-1:0] = m_re;
                3'd2: rd[W-1:0] = m_mask;
                3'd3: rd[W-1:0] = m_cap;
                3'd4: rd[W-1:0] = m_fe;
                default: rd = '0;
            endcase
            if (!armed) begin
                nf = s2; np = s2; newcap = '0;
                for (int i = 0; i < W; i++) m_run[i] = 0;
            end else begin
                np = m_filt;
                newcap = (m_filt & ~m_prev & m_re) | (~m_filt & m_prev & m_fe);
`ifdef CONTROLLER_PIO_IN_DEBOUNCE_EN
                nf = m_filt;
                for (int i = 0; i < W; i++) begin
                    if (s2[i] != m_filt[i]) begin
                        m_run[i]++;
                        if (m_run[i] >= DC) begin nf[i] = s2[i]; m_run[i] = 0; end
                    end else m_run[i] = 0;
                end
`else
                nf = s2;
`endif
            end
            clr = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
            m_cap = newcap | (m_cap & ~clr);
            if (wr && address == 3'd1) m_re   = writedata[W-1:0];
            if (wr && address == 3'd2) m_mask = writedata[W-1:0];
            if (wr && address == 3'd4) m_fe   = writedata[W-1:0];
            m_filt = nf; m_prev = np; m_rd = rd;
            if (m_edges < 1000) m_edges++;
            hist.push_front(in_port);
            if (hist.size() > 4) void'(hist.pop_back());
        end
        @(posedge clk); #1;
        chk("rdata", readdata, m_rd);
        chk("irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a);
        address = a;
        tick();
    endtask

    initial begin
        bit found;
        reset = 1'b1; in_port = 10'h3FF; address = '0; chipselect = 1'b0;
        write_n = 1'b1; writedata = '0;
        @(negedge clk);
        idle(3);
        chk("rst_rdata", readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        idle(DC + 8);
        bus_rd(3); chk("rst_cap", readdata, 32'h0);
        chk("rst_no_irq", {31'b0, irq}, 32'h0);
        bus_rd(0); chk("rst_data", readdata, 32'h3FF);

        // Rising capture on bit 0, then W1C.
        in_port = '0; idle(DC + 8);
        bus_wr(1, 32'h1); bus_wr(2, 32'h1);
        in_port[0] = 1'b1;
`ifndef CONTROLLER_PIO_IN_DEBOUNCE_EN
        idle(3); chk("rise_early", {31'b0, irq}, 32'h0);
        tick();  chk("rise_k3", {31'b0, irq}, 32'h1);
`endif
        idle(DC + 8);
        chk("rise_irq", {31'b0, irq}, 32'h1);
        bus_rd(3); chk("rise_cap", readdata, 32'h1);
        bus_wr(3, 32'h1);
        chk("clr_irq", {31'b0, irq}, 32'h0);
        bus_rd(3); chk("clr_cap", readdata, 32'h0);

        // Falling-only capture on bit 9.
        bus_wr(1, 32'h0); bus_wr(4, 32'h200);
        in_port[9] = 1'b1; idle(20);
        bus_rd(3); chk("fall_none_yet", readdata, 32'h0);
        in_port[9] = 1'b0; idle(20);
        bus_rd(3); chk("fall_cap", readdata, 32'h200);
        bus_wr(3, 32'h200); bus_wr(4, 32'h0);

        // Set wins: W1C of bit 3 on the very edge its rise is captured.
        bus_wr(1, 32'h8);
        in_port[3] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_filt[3] && !m_prev[3]) found = 1'b1;
            else tick();
        end
        chk("set_wins_found", {31'b0, found}, 32'h1);
        bus_wr(3, 32'h8);
        bus_rd(3); chk("set_wins", readdata & 32'h8, 32'h8);
        bus_wr(3, 32'h8);
        bus_rd(3); chk("set_wins_clr", readdata, 32'h0);

        // Masking on bit 5.
        bus_wr(2, 32'h0); bus_wr(1, 32'h20);
        in_port[5] = 1'b1; idle(DC + 8);
        chk("mask_off_irq", {31'b0, irq}, 32'h0);
        bus_wr(2, 32'h20);
        chk("mask_on_irq", {31'b0, irq}, 32'h1);
        bus_rd(3); chk("mask_cap", readdata, 32'h20);

        // Unmapped addresses read zero and ignore writes.
        bus_wr(6, 32'hFFFF_FFFF);
        bus_rd(6); chk("unmapped", readdata, 32'h0);
        bus_rd(2); chk("mask_kept", readdata, 32'h20);

`ifdef CONTROLLER_PIO_IN_DEBOUNCE_EN
        // Debounce: a glitch one cycle short never reaches DATA.
        bus_wr(1, 32'h24);
        address = 3'd0;
        in_port[2] = 1'b1; idle(DC - 1);
        in_port[2] = 1'b0; idle(DC + 8);
        bus_rd(0); chk("glitch_data", readdata & 32'h4, 32'h0);
        bus_rd(3); chk("glitch_cap", readdata, 32'h20);
        address = 3'd0;
        in_port[2] = 1'b1;
        idle(DC + 2); chk("deb_before", readdata & 32'h4, 32'h0);
        tick();       chk("deb_after", readdata & 32'h4, 32'h4);
        idle(4);
        bus_rd(3); chk("deb_cap", readdata, 32'h24);
`endif

        // Random pin and bus traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
            if ($urandom_range(0, 4) == 0) begin
                address = 3'($urandom_range(0, 7)); writedata = $urandom;
                chipselect = 1'b1; write_n = 1'b0;
            end else begin
                address = 3'($urandom_range(0, 7)); writedata = $urandom;
                chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1;
            end
            tick();
        end
        chipselect = 1'b0; write_n = 1'b1;

        // Reset mid-operation discards captures.
        reset = 1'b1; idle(2); reset = 1'b0;
        idle(6);
        bus_rd(3); chk("reset_mid_cap", readdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
